// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard_pkg: shared pipeline types and parameter defaults for the register scoreboard.
package regfile_scoreboard_pkg;
    localparam int XLEN_D     = 32;
    localparam int NREGS_D    = 32;
    localparam int NUM_READ_D = 2;
    localparam int MAX_PEND_D = 3;
    localparam int BYPASS_D   = 1;
    // Three bits hold every legal MAX_PEND (1..7).
    localparam int PW = 3;
    typedef logic [$clog2(NREGS_D)-1:0] reg_idx_t;
    typedef logic [PW-1:0] pend_t;
endpackage

// File: rtl/regfile_scoreboard_counter.sv
// sb_counter: saturating up/down count of outstanding writes to one register.
module sb_counter
    import regfile_scoreboard_pkg::*;
#(
    parameter int MAX_PEND = MAX_PEND_D
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  inc,
    input  logic  wr_hit,
    input  logic  clr,
    output pend_t cnt
);
    logic dec;
    // A writeback with nothing outstanding still writes data but leaves the count at 0.
    assign dec = wr_hit && cnt != '0;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && !dec && cnt < pend_t'(MAX_PEND)) cnt <= cnt + 1'b1;
        else if (dec && !inc) cnt <= cnt - 1'b1;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with per-register pending-write tracking, bypass and stall.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN     = XLEN_D,
    parameter int NREGS    = NREGS_D,
    parameter int NUM_READ = NUM_READ_D,
    parameter int MAX_PEND = MAX_PEND_D,
    parameter int BYPASS   = BYPASS_D,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_READ-1:0]                rd_req,
    input  logic [NUM_READ-1:0][AW-1:0]        rd_addr,
    output logic [NUM_READ-1:0][XLEN-1:0]      rd_data,
    output logic [NUM_READ-1:0]                rd_busy,
    input  logic                               wr_en,
    input  logic [AW-1:0]                      wr_addr,
    input  logic [XLEN-1:0]                    wr_data,
    input  logic                               issue_en,
    input  logic [AW-1:0]                      issue_addr,
    output logic                               issue_ready,
    input  logic                               flush,
    output logic                               stall
);
    logic [XLEN-1:0] regs [NREGS];
    pend_t           pend [NREGS];
    logic            issue_acc;

    assign pend[0] = '0;
    assign issue_ready = pend[issue_addr] < pend_t'(MAX_PEND) ||
                         (wr_en && wr_addr == issue_addr && pend[issue_addr] != '0);
    assign issue_acc = issue_en && issue_ready && issue_addr != '0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        sb_counter #(.MAX_PEND(MAX_PEND)) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .inc    (issue_acc && issue_addr == AW'(r)),
            .wr_hit (wr_en && wr_addr == AW'(r)),
            .clr    (flush),
            .cnt    (pend[r])
        );
    end

    // Entry 0 is never written, so it reads back as zero without a special case.
    always_ff @(posedge clk or posedge reset)
        if (reset) for (int k = 0; k < NREGS; k++) regs[k] <= '0;
        else if (wr_en && wr_addr != '0) regs[wr_addr] <= wr_data;

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            logic hit;
            hit = BYPASS != 0 && wr_en && wr_addr == rd_addr[i] && rd_addr[i] != '0;
            rd_data[i] = hit ? wr_data : regs[rd_addr[i]];
            // Last producer retiring this cycle frees the operand, unless a new issue re-arms it.
            rd_busy[i] = pend[rd_addr[i]] != '0 &&
                         !(hit && pend[rd_addr[i]] == pend_t'(1) && !(issue_acc && issue_addr == rd_addr[i]));
        end
    end

    assign stall = |(rd_req & rd_busy);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vectors with hand-computed expectations for regfile_scoreboard.
module tb_regfile_scoreboard;
    logic             clk = 0;
    logic             reset;
    logic [1:0]       rd_req;
    logic [1:0][4:0]  rd_addr;
    logic [1:0][31:0] rd_data;
    logic [1:0]       rd_busy;
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [31:0]      wr_data;
    logic             issue_en;
    logic [4:0]       issue_addr;
    logic             issue_ready;
    logic             flush;
    logic             stall;
    int nvec = 0;
    int nmis = 0;

    regfile_scoreboard dut (
        .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .flush(flush), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; issue_en = 0; flush = 0; rd_req = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
    endtask

    task automatic iss(input logic [4:0] a);
        issue_en = 1; issue_addr = a;
    endtask

    initial begin
        reset = 1; idle(); rd_addr = '0; wr_addr = 0; wr_data = 0; issue_addr = 5;
        #2;
        check("rst_data", rd_data[0], 0);
        check("rst_busy", 32'(rd_busy), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_ready", 32'(issue_ready), 1);
        tick(); reset = 0;

        wr(7, 32'h11); tick(); idle();
        rd_addr[0] = 7; #1;
        check("x7_stored", rd_data[0], 32'h11);
        wr(7, 32'hAB); #1;
        check("x7_bypass", rd_data[0], 32'hAB);
        tick(); idle(); #1;
        check("x7_after", rd_data[0], 32'hAB);

        wr(0, 32'hFF); rd_addr[0] = 0; #1;
        check("x0_bypass", rd_data[0], 0);
        tick(); idle(); #1;
        check("x0_read", rd_data[0], 0);

        rd_addr[0] = 3;
        for (int n = 0; n < 3; n++) begin
            iss(3); #1;
            check("x3_ready_pre", 32'(issue_ready), 1);
            tick();
        end
        idle(); issue_addr = 3; #1;
        check("x3_busy_sat", 32'(rd_busy[0]), 1);
        check("x3_ready_sat", 32'(issue_ready), 0);
        iss(3); tick(); idle();
        wr(3, 32'h33); #1;
        check("x3_ready_wb", 32'(issue_ready), 1);
        check("x3_busy_wb", 32'(rd_busy[0]), 1);
        tick(); idle(); #1;
        check("x3_busy_p2", 32'(rd_busy[0]), 1);
        check("x3_ready_p2", 32'(issue_ready), 1);
        wr(3, 32'h34); tick(); idle(); #1;
        check("x3_busy_p1", 32'(rd_busy[0]), 1);
        wr(3, 32'h35); #1;
        check("x3_busy_free", 32'(rd_busy[0]), 0);
        tick(); idle(); #1;
        check("x3_busy_p0", 32'(rd_busy[0]), 0);
        check("x3_data", rd_data[0], 32'h35);

        rd_addr[0] = 4;
        iss(4); tick(); idle();
        iss(4); wr(4, 32'h44); #1;
        check("x4_busy_same", 32'(rd_busy[0]), 1);
        tick(); idle(); #1;
        check("x4_busy_after", 32'(rd_busy[0]), 1);
        check("x4_data", rd_data[0], 32'h44);
        wr(4, 32'h45); tick(); idle(); #1;
        check("x4_busy_clear", 32'(rd_busy[0]), 0);

        rd_addr[0] = 6;
        wr(6, 32'h66); tick(); idle(); issue_addr = 6; #1;
        check("x6_data", rd_data[0], 32'h66);
        check("x6_busy", 32'(rd_busy[0]), 0);
        check("x6_ready", 32'(issue_ready), 1);
        iss(6); tick(); idle(); #1;
        check("x6_busy_iss", 32'(rd_busy[0]), 1);

        iss(9); tick(); idle();
        rd_addr[0] = 9; rd_addr[1] = 9; rd_req = 2'b01; #1;
        check("x9_stall", 32'(stall), 1);
        rd_req = 2'b00; #1;
        check("x9_nostall", 32'(stall), 0);
        check("x9_busy_noreq", 32'(rd_busy), 2'b11);
        rd_req = 2'b10; #1;
        check("x9_stall_p1", 32'(stall), 1);
        flush = 1; wr(9, 32'h99); iss(9); tick(); idle();
        rd_req = 2'b01; #1;
        check("flush_stall", 32'(stall), 0);
        check("flush_data", rd_data[0], 32'h99);
        rd_addr[1] = 6; #1;
        check("flush_x6", 32'(rd_busy[1]), 0);

        rd_addr[0] = 0; rd_req = 2'b01;
        for (int n = 0; n < 4; n++) begin
            iss(0); #1;
            check("x0_ready", 32'(issue_ready), 1);
            tick();
        end
        idle(); #1;
        check("x0_busy", 32'(rd_busy[0]), 0);

        wr(5, 32'h55); tick(); idle();
        iss(5); tick(); iss(5); tick(); idle();
        rd_addr[0] = 5; issue_addr = 5; #1;
        check("x5_busy_pre", 32'(rd_busy[0]), 1);
        #1; wr(8, 32'h77); iss(8); reset = 1; #1;
        wr_en = 0; issue_en = 0; #1;
        check("mid_rst_busy", 32'(rd_busy[0]), 0);
        check("mid_rst_data", rd_data[0], 0);
        check("mid_rst_ready", 32'(issue_ready), 1);
        tick(); reset = 0; idle();
        rd_addr[1] = 8; #1;
        check("x8_data_rst", rd_data[1], 0);
        check("x8_busy_rst", 32'(rd_busy[1]), 0);
        wr(8, 32'h88); tick(); idle(); #1;
        check("x8_data_post", rd_data[1], 32'h88);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
